// File: rtl/xfs_pkg.sv
// Shared types and constants for the XOR-fold scheduler.
// XFS_BYPASS_EN: when defined, level 0 skips folding and returns the word unchanged.
package xfs_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MAX_LVL = 5;
  localparam int unsigned LVL_W   = 3;
  localparam int unsigned WID_W   = 6;

  typedef logic [LVL_W-1:0] lvl_t;
  typedef logic [WID_W-1:0] width_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FOLD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    XFS_IDLE = ST_IDLE,
    XFS_FOLD = ST_FOLD,
    XFS_DONE = ST_DONE
  } xfs_state_e;

  // Effective fold count: clamp to MAX_LVL; level 0 is a bypass or a single fold.
  function automatic lvl_t eff_lvl(input lvl_t lvl);
    lvl_t r;
    if (lvl > lvl_t'(MAX_LVL)) begin
      r = lvl_t'(MAX_LVL);
    end else if (lvl == lvl_t'(0)) begin
`ifdef XFS_BYPASS_EN
      r = lvl_t'(0);
`else
      r = lvl_t'(1);
`endif
    end else begin
      r = lvl;
    end
    return r;
  endfunction

endpackage

// File: rtl/xor_fold_stage.sv
// One combinational fold level: low half of the active width XORed with the high half, rest cleared.
module xor_fold_stage
  import xfs_pkg::*;
(
  input  logic [DATA_W-1:0] i_word,
  input  width_t            i_width,
  output logic [DATA_W-1:0] o_word
);

  logic [WID_W-1:0]  w_half;
  logic [DATA_W-1:0] w_mask;

  assign w_half = i_width >> 1;
  assign w_mask = (DATA_W'(1) << w_half) - DATA_W'(1);
  assign o_word = (i_word ^ (i_word >> w_half)) & w_mask;

endmodule

// File: rtl/xor_fold_sched.sv
// Two-requester round-robin scheduler that folds a 32-bit word down by XOR, one level per cycle.
// XFS_BYPASS_EN: when defined, level-0 jobs go straight to DONE with the word unchanged.
module xor_fold_sched
  import xfs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  input  logic [LVL_W-1:0]  a_lvl,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  input  logic [LVL_W-1:0]  b_lvl,
  output logic              b_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_id,
  input  logic              out_ready
);

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_work;
  width_t            r_width;
  lvl_t              r_lvl;
  logic              r_id;
  logic              r_last_b;
  logic              r_rdy_en;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_id;

  logic [1:0]        w_state_nxt;
  logic [DATA_W-1:0] w_work_nxt;
  width_t            w_width_nxt;
  lvl_t              w_lvl_nxt;
  logic              w_id_nxt;
  logic              w_last_b_nxt;
  logic              w_out_valid_nxt;
  logic [DATA_W-1:0] w_out_data_nxt;
  logic              w_out_id_nxt;

  logic              w_idle_rdy;
  logic              w_pick_a;
  logic              w_pick_b;
  logic              w_accept;
  logic [DATA_W-1:0] w_acc_data;
  lvl_t              w_acc_lvl;
  logic [DATA_W-1:0] w_folded;

  // Grants are only offered in IDLE, and never in the first cycle after reset.
  assign w_idle_rdy = (r_state == ST_IDLE) && r_rdy_en && !rst;
  assign w_pick_a   = a_valid && (!b_valid || r_last_b);
  assign w_pick_b   = b_valid && (!a_valid || !r_last_b);
  assign a_ready    = w_idle_rdy && w_pick_a;
  assign b_ready    = w_idle_rdy && w_pick_b;
  assign w_accept   = w_idle_rdy && (a_valid || b_valid);
  assign w_acc_data = w_pick_b ? b_data : a_data;
  assign w_acc_lvl  = eff_lvl(w_pick_b ? b_lvl : a_lvl);

  assign out_valid = r_out_valid && !rst;
  assign out_data  = rst ? '0 : r_out_data;
  assign out_id    = r_out_id && !rst;

  xor_fold_stage u_stage (
    .i_word  (r_work),
    .i_width (r_width),
    .o_word  (w_folded)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_work_nxt   = r_work;
    w_width_nxt  = r_width;
    w_lvl_nxt    = r_lvl;
    w_id_nxt     = r_id;
    w_last_b_nxt = r_last_b;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_work_nxt   = w_acc_data;
          w_width_nxt  = width_t'(DATA_W);
          w_lvl_nxt    = w_acc_lvl;
          w_id_nxt     = w_pick_b;
          w_last_b_nxt = w_pick_b;
          w_state_nxt  = (w_acc_lvl == lvl_t'(0)) ? ST_DONE : ST_FOLD;
        end
      end
      ST_FOLD: begin
        w_work_nxt  = w_folded;
        w_width_nxt = r_width >> 1;
        w_lvl_nxt   = r_lvl - lvl_t'(1);
        if (r_lvl <= lvl_t'(1)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Result ports track the work register only while in DONE, zero elsewhere.
    w_out_valid_nxt = (w_state_nxt == ST_DONE);
    w_out_data_nxt  = w_out_valid_nxt ? w_work_nxt : '0;
    w_out_id_nxt    = w_out_valid_nxt && w_id_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_work      <= '0;
      r_width     <= width_t'(DATA_W);
      r_lvl       <= '0;
      r_id        <= 1'b0;
      r_last_b    <= 1'b1;
      r_rdy_en    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_work      <= w_work_nxt;
      r_width     <= w_width_nxt;
      r_lvl       <= w_lvl_nxt;
      r_id        <= w_id_nxt;
      r_last_b    <= w_last_b_nxt;
      r_rdy_en    <= 1'b1;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_id    <= w_out_id_nxt;
    end
  end

endmodule

// File: tb/tb_xor_fold_sched.sv
// Directed self-checking bench for xor_fold_sched (honours XFS_BYPASS_EN for level-0 expectations).
module tb_xor_fold_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic [31:0] a_data, b_data;
  logic [2:0]  a_lvl, b_lvl;
  logic        a_ready, b_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_id;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  xor_fold_sched dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_lvl     (a_lvl),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_lvl     (b_lvl),
    .b_ready   (b_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Submit one job and wait for its result; lat is cycles from accept to first out_valid (-1 on timeout).
  task automatic run_job(input bit use_b, input logic [31:0] d, input logic [2:0] l,
                         output logic [31:0] od, output logic oid, output int lat);
    int n;
    int acc;
    @(negedge clk);
    if (use_b) begin b_valid = 1'b1; b_data = d; b_lvl = l; end
    else       begin a_valid = 1'b1; a_data = d; a_lvl = l; end
    #1;
    n = 0;
    while (!(use_b ? b_ready : a_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    acc = cyc;
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk); n++;
    end
    lat = out_valid ? (cyc - acc) : -1;
    od  = out_data;
    oid = out_id;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
    a_data = 32'hFFFF_FFFF; b_data = 32'hFFFF_FFFF; a_lvl = 3'd1; b_lvl = 3'd1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_checks++; if (out_id !== 1'b0) begin n_fail++; $display("FAIL reset_out_id got %b want 0", out_id); end
    n_checks++; if ({a_ready, b_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", {a_ready, b_ready}); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if ({a_ready, b_ready} !== 2'b00) begin n_fail++; $display("FAIL ready_first_cycle_after_rst got %b want 00", {a_ready, b_ready}); end
    @(negedge clk); #1;
    n_checks++; if ({a_ready, b_ready} !== 2'b10) begin n_fail++; $display("FAIL first_tie_grant got %b want 10", {a_ready, b_ready}); end
    a_valid = 1'b0; b_valid = 1'b0;
    do_reset();
  endtask

  task automatic test_single_a();
    logic [31:0] od; logic oid; int lat;
    run_job(1'b0, 32'hFFFF_0000, 3'd1, od, oid, lat);
    n_checks++; if (od !== 32'h0000_FFFF) begin n_fail++; $display("FAIL lvl1_data got %h want 0000ffff", od); end
    n_checks++; if (oid !== 1'b0) begin n_fail++; $display("FAIL lvl1_id got %b want 0", oid); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL lvl1_latency got %0d want 2", lat); end
    run_job(1'b0, 32'h8000_0001, 3'd5, od, oid, lat);
    n_checks++; if (od !== 32'h0) begin n_fail++; $display("FAIL lvl5_even_data got %h want 0", od); end
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL lvl5_even_latency got %0d want 6", lat); end
    run_job(1'b0, 32'h0000_0001, 3'd5, od, oid, lat);
    n_checks++; if (od !== 32'h1) begin n_fail++; $display("FAIL lvl5_odd_data got %h want 1", od); end
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL lvl5_odd_latency got %0d want 6", lat); end
  endtask

  task automatic test_single_b();
    logic [31:0] od; logic oid; int lat;
    // DEAD^BEEF = 6042, then 60^42 = 22
    run_job(1'b1, 32'hDEAD_BEEF, 3'd2, od, oid, lat);
    n_checks++; if (od !== 32'h22) begin n_fail++; $display("FAIL b_lvl2_data got %h want 22", od); end
    n_checks++; if (oid !== 1'b1) begin n_fail++; $display("FAIL b_lvl2_id got %b want 1", oid); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL b_lvl2_latency got %0d want 3", lat); end
  endtask

  task automatic test_lvl_clamp();
    logic [31:0] od; logic oid; int lat;
    run_job(1'b0, 32'h0001_0003, 3'd7, od, oid, lat);
    n_checks++; if (od !== 32'h1) begin n_fail++; $display("FAIL lvl7_data got %h want 1", od); end
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL lvl7_latency got %0d want 6", lat); end
  endtask

  task automatic test_lvl0();
    logic [31:0] od; logic oid; int lat;
    logic [31:0] exp_d; int exp_lat;
`ifdef XFS_BYPASS_EN
    exp_d = 32'hFFFF_0000; exp_lat = 1;
`else
    exp_d = 32'h0000_FFFF; exp_lat = 2;
`endif
    run_job(1'b0, 32'hFFFF_0000, 3'd0, od, oid, lat);
    n_checks++; if (od !== exp_d) begin n_fail++; $display("FAIL lvl0_data got %h want %h", od, exp_d); end
    n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL lvl0_latency got %0d want %0d", lat, exp_lat); end
  endtask

  task automatic test_round_robin();
    logic        g [8];
    logic        rid [8];
    logic [31:0] rdat [8];
    int ng; int nr;
    do_reset();
    ng = 0; nr = 0;
    a_data = 32'hFFFF_0000; a_lvl = 3'd1;
    b_data = 32'h1234_5678; b_lvl = 3'd2;
    a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (a_ready && ng < 8) begin g[ng] = 1'b0; ng++; end
      if (b_ready && ng < 8) begin g[ng] = 1'b1; ng++; end
      if (out_valid && nr < 8) begin rid[nr] = out_id; rdat[nr] = out_data; nr++; end
      @(negedge clk);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    n_checks++; if (ng < 3) begin n_fail++; $display("FAIL rr_grant_count got %0d want >=3", ng); end
    n_checks++; if (nr < 3) begin n_fail++; $display("FAIL rr_result_count got %0d want >=3", nr); end
    if (ng >= 3) begin
      n_checks++; if ({g[0], g[1], g[2]} !== 3'b010) begin n_fail++; $display("FAIL rr_grant_order got %b want 010", {g[0], g[1], g[2]}); end
    end
    if (nr >= 3) begin
      n_checks++; if ({rid[0], rid[1], rid[2]} !== 3'b010) begin n_fail++; $display("FAIL rr_result_ids got %b want 010", {rid[0], rid[1], rid[2]}); end
      n_checks++; if (rdat[0] !== 32'h0000_FFFF) begin n_fail++; $display("FAIL rr_a_data got %h want 0000ffff", rdat[0]); end
      // 1234^5678 = 444C, then 44^4C = 08
      n_checks++; if (rdat[1] !== 32'h0000_0008) begin n_fail++; $display("FAIL rr_b_data got %h want 00000008", rdat[1]); end
      n_checks++; if (rdat[2] !== 32'h0000_FFFF) begin n_fail++; $display("FAIL rr_a2_data got %h want 0000ffff", rdat[2]); end
    end
    do_reset();
  endtask

  task automatic test_backpressure();
    logic [31:0] od; logic oid; int lat;
    out_ready = 1'b0;
    run_job(1'b0, 32'hFFFF_0000, 3'd1, od, oid, lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL bp_latency got %0d want 2", lat); end
    b_valid = 1'b1; b_data = 32'h0000_00F0; b_lvl = 3'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_hold%0d got %b want 1", i, out_valid); end
      n_checks++; if (out_data !== 32'h0000_FFFF) begin n_fail++; $display("FAIL bp_data_hold%0d got %h want 0000ffff", i, out_data); end
      n_checks++; if (out_id !== 1'b0) begin n_fail++; $display("FAIL bp_id_hold%0d got %b want 0", i, out_id); end
      n_checks++; if ({a_ready, b_ready} !== 2'b00) begin n_fail++; $display("FAIL bp_ready_hold%0d got %b want 00", i, {a_ready, b_ready}); end
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if ({a_ready, b_ready} !== 2'b00) begin n_fail++; $display("FAIL bp_ready_handshake_cycle got %b want 00", {a_ready, b_ready}); end
    @(negedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_after got %b want 0", out_valid); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL bp_data_after got %h want 0", out_data); end
    n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle_grant got %b want 1", b_ready); end
    b_valid = 1'b0;
    do_reset();
  endtask

  task automatic test_reset_midfold();
    int seen;
    a_data = 32'h0000_0001; a_lvl = 3'd5;
    @(negedge clk);
    a_valid = 1'b1;
    #1;
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL mf_accept got %b want 1", a_ready); end
    @(negedge clk);
    a_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mf_valid_after_rst got %b want 0", out_valid); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL mf_data_after_rst got %h want 0", out_data); end
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (out_valid) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL mf_stale_result got %0d valid cycles want 0", seen); end
    a_valid = 1'b1;
    #1;
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL mf_idle_after got %b want 1", a_ready); end
    a_valid = 1'b0;
    do_reset();
  endtask

  initial begin
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
    a_data = '0; b_data = '0; a_lvl = '0; b_lvl = '0;
    test_reset();
    test_single_a();
    test_single_b();
    test_lvl_clamp();
    test_lvl0();
    test_round_robin();
    test_backpressure();
    test_reset_midfold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
